// File: rtl/regfile16_sb.sv
// Sixteen-entry 2R/1W register file with a pending-write scoreboard.
// Index 15 is the hardwired zero register: no storage, never pending.
module regfile16_sb #(
  parameter int WIDTH  = 64,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [3:0]       iss_rd,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             pend_a,
  output logic             pend_b,
  output logic [15:0]      pending
);

  localparam logic [3:0] ZERO_REG = 4'd15;

  logic [WIDTH-1:0] regs [0:14];
  logic [14:0]      pend_q;
  logic             wr_live;
  logic             byp_a;
  logic             byp_b;

  assign wr_live = wr_en && (wr_addr != ZERO_REG);
  assign pending = {1'b0, pend_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Issue is tested first so a younger producer keeps ownership when it
  // collides with an older writeback to the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (iss_en && (iss_rd == 4'(i))) begin
          pend_q[i] <= 1'b1;
        end else if (wr_en && (wr_addr == 4'(i))) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign byp_a = BYPASS && wr_live && (wr_addr == rd_addr_a);
  assign byp_b = BYPASS && wr_live && (wr_addr == rd_addr_b);

  // During reset the array still holds stale data until the edge, so
  // stored-state reads are masked; the forwarded write path is not.
  always_comb begin
    rd_data_a = '0;
    pend_a    = 1'b0;
    if (rd_addr_a == ZERO_REG) begin
      rd_data_a = '0;
      pend_a    = 1'b0;
    end else if (byp_a) begin
      rd_data_a = wr_data;
      pend_a    = 1'b0;
    end else if (!reset) begin
      rd_data_a = regs[rd_addr_a];
      pend_a    = pend_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    pend_b    = 1'b0;
    if (rd_addr_b == ZERO_REG) begin
      rd_data_b = '0;
      pend_b    = 1'b0;
    end else if (byp_b) begin
      rd_data_b = wr_data;
      pend_b    = 1'b0;
    end else if (!reset) begin
      rd_data_b = regs[rd_addr_b];
      pend_b    = pend_q[rd_addr_b];
    end
  end

endmodule

// File: tb/tb_regfile16_sb.sv
// Bench for regfile16_sb: one bypassing and one non-bypassing instance share
// stimulus and are compared against an array-based model of the register file.
module tb_regfile16_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [3:0]  iss_rd;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;

  // index 0 = BYPASS=1 instance, index 1 = BYPASS=0 instance
  logic [63:0] rd_a [2];
  logic [63:0] rd_b [2];
  logic        pa   [2];
  logic        pb   [2];
  logic [15:0] pend [2];

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [15];
  logic [15:0] m_pend;

  always #5 clk = ~clk;

  regfile16_sb #(.WIDTH(64), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a[0]), .rd_data_b(rd_b[0]), .pend_a(pa[0]), .pend_b(pb[0]),
    .pending(pend[0])
  );

  regfile16_sb #(.WIDTH(64), .BYPASS(1'b0)) u_nob (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_a[1]), .rd_data_b(rd_b[1]), .pend_a(pa[1]), .pend_b(pb[1]),
    .pending(pend[1])
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] exp_data(input bit byp, input logic [3:0] addr);
    if (addr == 4'd15) return 64'h0;
    if (byp && wr_en && wr_addr == addr) return wr_data;
    if (reset) return 64'h0;
    return m_regs[addr];
  endfunction

  function automatic logic exp_pnd(input bit byp, input logic [3:0] addr);
    if (addr == 4'd15) return 1'b0;
    if (byp && wr_en && wr_addr == addr) return 1'b0;
    if (reset) return 1'b0;
    return m_pend[addr];
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
      m_pend = 16'h0;
    end else begin
      if (wr_en && wr_addr != 4'd15) m_regs[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (iss_en && iss_rd != 4'd15) m_pend[iss_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    wr_addr = 4'd0; wr_data = 64'h0; iss_rd = 4'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 15; i++) begin
      idle();
      wr_en = 1'b1; wr_addr = 4'(i);
      wr_data = {$urandom, $urandom} | 64'h1;
      iss_en = 1'b1; iss_rd = 4'(14 - i);
      tick();
    end
    idle();
    reset = 1'b1;
    rd_addr_a = 4'd3; rd_addr_b = 4'd11;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd_a[d] !== 64'h0 || rd_b[d] !== 64'h0) begin
        errors++;
        $display("FAIL reset_comb_read dut%0d: a=%h b=%h expected 0", d, rd_a[d], rd_b[d]);
      end
    end
    tick();
    idle();
    for (int i = 0; i < 15; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(14 - i);
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd_a[d] !== 64'h0 || rd_b[d] !== 64'h0) begin
          errors++;
          $display("FAIL reset_read dut%0d addr %0d: a=%h b=%h expected 0", d, i, rd_a[d], rd_b[d]);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_pending dut%0d: got %h expected 0000", d, pend[d]);
      end
    end
  endtask

  task automatic test_write_zero();
    idle();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 64'hDEAD_BEEF_0123_4567;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 64'h1;
    tick();
    idle();
    rd_addr_a = 4'd3; rd_addr_b = 4'd3;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd_a[d] !== 64'hDEAD_BEEF_0123_4567 || rd_b[d] !== 64'hDEAD_BEEF_0123_4567) begin
        errors++;
        $display("FAIL write_read dut%0d: a=%h b=%h expected deadbeef01234567", d, rd_a[d], rd_b[d]);
      end
    end
    rd_addr_a = 4'd15; rd_addr_b = 4'd15;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd_a[d] !== 64'h0 || rd_b[d] !== 64'h0 || pa[d] !== 1'b0 || pend[d][15] !== 1'b0) begin
        errors++;
        $display("FAIL zero_reg dut%0d: a=%h b=%h pa=%b p15=%b expected 0", d, rd_a[d], rd_b[d], pa[d], pend[d][15]);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'h11;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'h55;
    rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    checks++;
    if (rd_a[0] !== 64'h55) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 55", rd_a[0]);
    end
    checks++;
    if (rd_a[1] !== 64'h11) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h expected 11", rd_a[1]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_a[1] !== 64'h55 || rd_b[1] !== 64'h55) begin
      errors++;
      $display("FAIL nobypass_next_cycle: a=%h b=%h expected 55", rd_a[1], rd_b[1]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1'b1; iss_rd = 4'd5;
    rd_addr_a = 4'd5;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pa[d] !== 1'b0) begin
        errors++;
        $display("FAIL issue_not_forwarded dut%0d: pend_a=%b expected 0", d, pa[d]);
      end
    end
    tick();
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d][5] !== 1'b1 || pa[d] !== 1'b1) begin
        errors++;
        $display("FAIL sb_set dut%0d: pending5=%b pend_a=%b expected 1", d, pend[d][5], pa[d]);
      end
    end
    tick();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 64'h1234;
    #1;
    checks++;
    if (pa[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear_bypass: pend_a=%b expected 0", pa[0]);
    end
    checks++;
    if (pa[1] !== 1'b1) begin
      errors++;
      $display("FAIL sb_clear_nobypass: pend_a=%b expected 1", pa[1]);
    end
    tick();
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d][5] !== 1'b0 || pa[d] !== 1'b0) begin
        errors++;
        $display("FAIL sb_cleared dut%0d: pending5=%b pend_a=%b expected 0", d, pend[d][5], pa[d]);
      end
    end
  endtask

  task automatic test_simultaneous();
    idle();
    iss_en = 1'b1; iss_rd = 4'd9;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 64'hA;
    tick();
    idle();
    rd_addr_b = 4'd9;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rd_b[d] !== 64'hA || pend[d][9] !== 1'b1 || pb[d] !== 1'b1) begin
        errors++;
        $display("FAIL issue_wins dut%0d: data=%h pending9=%b pend_b=%b expected a/1/1", d, rd_b[d], pend[d][9], pb[d]);
      end
    end
    iss_en = 1'b1; iss_rd = 4'd9;
    tick();
    idle();
    iss_en = 1'b1; iss_rd = 4'd15;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 64'hB;
    tick();
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0) begin
        errors++;
        $display("FAIL reissue_one_clear dut%0d: pending=%h expected 0000", d, pend[d]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    idle();
    for (int r = 4; r < 8; r++) begin
      iss_en = 1'b1; iss_rd = 4'(r);
      wr_en = 1'b1; wr_addr = 4'(r); wr_data = 64'(r) + 64'h100;
      tick();
    end
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h00F0) begin
        errors++;
        $display("FAIL preload_pending dut%0d: got %h expected 00f0", d, pend[d]);
      end
    end
    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 64'hFACE;
    rd_addr_a = 4'd4;
    #1;
    checks++;
    if (rd_a[0] !== 64'hFACE) begin
      errors++;
      $display("FAIL reset_bypass: got %h expected face", rd_a[0]);
    end
    checks++;
    if (rd_a[1] !== 64'h0) begin
      errors++;
      $display("FAIL reset_nobypass: got %h expected 0", rd_a[1]);
    end
    tick();
    idle();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pend[d] !== 16'h0 || rd_a[d] !== 64'h0) begin
        errors++;
        $display("FAIL midflight_reset dut%0d: pending=%h reg4=%h expected 0", d, pend[d], rd_a[d]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 40) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_addr   = 4'($urandom_range(0, 15));
      wr_data   = {$urandom, $urandom};
      iss_en    = $urandom_range(0, 1);
      iss_rd    = 4'($urandom_range(0, 15));
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd_addr_a = wr_addr;
      #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rd_a[d] !== exp_data(d == 0, rd_addr_a) || rd_b[d] !== exp_data(d == 0, rd_addr_b)) begin
          errors++;
          $display("FAIL rand_data dut%0d cyc %0d: a=%h b=%h expected a=%h b=%h", d, c,
                   rd_a[d], rd_b[d], exp_data(d == 0, rd_addr_a), exp_data(d == 0, rd_addr_b));
        end
        checks++;
        if (pa[d] !== exp_pnd(d == 0, rd_addr_a) || pb[d] !== exp_pnd(d == 0, rd_addr_b)) begin
          errors++;
          $display("FAIL rand_pend dut%0d cyc %0d: pa=%b pb=%b expected pa=%b pb=%b", d, c,
                   pa[d], pb[d], exp_pnd(d == 0, rd_addr_a), exp_pnd(d == 0, rd_addr_b));
        end
        checks++;
        if (pend[d] !== m_pend) begin
          errors++;
          $display("FAIL rand_pending dut%0d cyc %0d: got %h expected %h", d, c, pend[d], m_pend);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
    m_pend = 16'h0;
    reset = 1'b1;
    @(negedge clk);
    tick();
    test_reset();
    test_write_zero();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile16_sb.md
# regfile16_sb

Sixteen-entry, two-read/one-write register file with an integrated pending-write scoreboard for the ARM datapath. It sits directly upstream of the per-bit 16:1 operand-select mux trees and supplies the decode stage's two source operands. It also reports per-register busy status so the hazard unit can stall on outstanding writes. Register 15 is the hardwired zero register.

## Interface
- WIDTH, 64, data width of each register
- BYPASS, 1, 1 = write-port data and scoreboard clear forward to the read ports in the same cycle; 0 = no forwarding
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  writeback enable
- wr_addr  input  4  writeback register index
- wr_data  input  WIDTH  writeback data
- iss_en  input  1  an instruction with a destination issued this cycle
- iss_rd  input  4  destination index of the issuing instruction
- rd_addr_a  input  4  read port A index
- rd_addr_b  input  4  read port B index
- rd_data_a  output  WIDTH  port A data (combinational)
- rd_data_b  output  WIDTH  port B data (combinational)
- pend_a  output  1  port A register has an outstanding write
- pend_b  output  1  port B register has an outstanding write
- pending  output  16  registered scoreboard vector, bit i = register i busy

## Operation
- Storage:
  - 15 registers of WIDTH bits, indices 0–14.
  - Index 15 has no storage. It always reads 0 and is never pending.
- Write:
  - On a clk edge with wr_en=1 and wr_addr≠15, reg[wr_addr] ← wr_data.
  - wr_addr=15 is a no-op.
- Scoreboard, per bit i, next state in priority order:
  - reset → 0.
  - iss_en && iss_rd==i && i≠15 → 1.
  - wr_en && wr_addr==i → 0.
  - Otherwise hold.
- Simultaneous issue and writeback to the same register:
  - Issue wins and pending stays 1, because a younger producer now owns the register.
  - The data write still occurs.
- Read, port X ∈ {a, b}:
  - rd_addr_X==15 → rd_data_X=0, pend_X=0.
  - BYPASS=1 and wr_en && wr_addr==rd_addr_X → rd_data_X=wr_data and pend_X=0.
  - Otherwise rd_data_X=reg[rd_addr_X] and pend_X=pending[rd_addr_X].
  - With BYPASS=0, reads always return stored state and pend_X = pending bit.
- Both ports may address the same register; both return identical results.
- Issue of a register that is already pending keeps it pending (no counter). One writeback clears it.
- Writeback to a non-pending register is legal. Data is written and the bit stays 0.

## Timing
- Reset is synchronous: all 15 registers → 0 and pending → 16'h0000 on the first clk edge with reset=1.
- While reset is high:
  - wr_en and iss_en are ignored.
  - The read ports still read combinationally and return 0, except when bypassing (BYPASS=1, wr_en=1, wr_addr≠15).
- Reset asserted mid-operation discards all pending state and all data at that edge.
- Write latency:
  - 1 cycle; data is visible from stored state in the cycle after the edge.
  - With BYPASS=1, data is also visible in the same cycle.
- Scoreboard latency:
  - Set takes effect one cycle after iss_en. pend_X is not forwarded from iss_en in the same cycle.
  - Clear is visible on pend_X in the same cycle when BYPASS=1, and one cycle later when BYPASS=0.
- No handshake: every input is sampled every cycle, and there is no backpressure.
- Read paths are purely combinational from rd_addr_X, register state, and wr_* (when BYPASS=1).

## Test plan
- Reset then read:
  - Stimulus: pre-fill regs with nonzero data, assert reset one cycle.
  - Response: rd_data_a/b=0 for addresses 0–14, pending=0.
- Write/read and zero register:
  - Stimulus: write 64'hDEAD_BEEF_0123_4567 to reg 3, then write 64'h1 to reg 15.
  - Response: next cycle reg 3 reads DEAD_BEEF_0123_4567 on both ports; reg 15 reads 0.
- Bypass (BYPASS=1):
  - Stimulus: rd_addr_a=7 while wr_en=1, wr_addr=7, wr_data=64'h55.
  - Response: rd_data_a=64'h55 in the same cycle.
  - Repeat with BYPASS=0: response is the old value that cycle, 64'h55 the next.
- Scoreboard life cycle:
  - Stimulus: iss_en with iss_rd=5; two cycles later wr_en=1, wr_addr=5.
  - Response: pending[5]=1 from cycle+1.
  - Response: pend_a(addr 5)=1 until the writeback cycle, then 0 (same cycle with BYPASS=1).
  - Response: pending[5]=0 after the edge.
- Simultaneous issue and writeback:
  - Stimulus: iss_en, iss_rd=9, wr_en, wr_addr=9, wr_data=64'hA in one cycle.
  - Response: reg 9=64'hA and pending[9]=1 afterwards.
  - Stimulus: iss_rd=15.
  - Response: pending[15] stays 0.
- Reset mid-flight:
  - Stimulus: pending=16'h00F0, assert reset together with wr_en to reg 4.
  - Response: pending=0, reg 4=0 after the edge.
